// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback.
// Latency: outputs are combinational from the current state (plus mem_ready in memory states);
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE while mem_ready=0, faults after MEM_TIMEOUT waits.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset (FSM -> FETCH, fault cleared)
//   op                opcode from the instruction register
//   mem_ready         shared memory port accepts/returns data this cycle
//   mem_req/mem_write/adr_src   memory access request, store flag, address select
//   ir_write/pc_write/branch/reg_write   datapath write enables
//   alu_src_a/alu_src_b/alu_op/result_src   datapath mux selects
//   fault             sticky illegal-opcode / memory-timeout indicator
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // The counter only has to represent 0..MEM_TIMEOUT-1: the wait that would
    // bring it to MEM_TIMEOUT is the one that diverts to FAULT instead.
    localparam int             CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit             TO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [CW-1:0]  CNT_LAST = TO_EN ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_wait;
    logic            timeout_hit;

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_wait   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        fault      = 1'b0;

        // While reset is asserted every output stays at its default value.
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        mem_wait = 1'b1;
                        if (timeout_hit) state_d = S_FAULT;
                    end
                end
                S_DECODE: begin
                    // Precompute old_pc + imm for branch/jal targets.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_BR:             state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_FAULT;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else begin
                        mem_wait = 1'b1;
                        if (timeout_hit) state_d = S_FAULT;
                    end
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        mem_wait = 1'b1;
                        if (timeout_hit) state_d = S_FAULT;
                    end
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    // PC takes the target latched in DECODE while ALU forms old_pc+4 for rd.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = S_JALR2;
                end
                S_JALR2: begin
                    // PC takes rd1+imm from ALU-out; ALU forms old_pc+4 for rd.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    state_d   = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    state_d   = S_ALUWB;
                end
                S_FAULT: begin
                    fault   = 1'b1;
                    state_d = S_FAULT;
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    // Every entry into a memory state is a state change, so clearing on any
    // transition gives each access a fresh wait budget.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_wait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write, fault;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

    always #5 clk = ~clk;

    multicycle_controller #(.RESET_STATE(4'd0), .MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .fault      (fault)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       fault;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       rdy;
        ctrl_t      exp;
        string      tag;
    } vec_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    vec_t  vecs[$];
    ctrl_t exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // en = {mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write}
    function automatic ctrl_t mk(input logic [6:0] en, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] aop, input logic [1:0] res, input logic f);
        ctrl_t c;
        {c.mem_req, c.mem_write, c.adr_src, c.ir_write, c.pc_write, c.branch, c.reg_write} = en;
        c.alu_src_a  = a;
        c.alu_src_b  = b;
        c.alu_op     = aop;
        c.result_src = res;
        c.fault      = f;
        return c;
    endfunction

    ctrl_t C_DEF, C_FETCH, C_FETCHR, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_MEMWR;
    ctrl_t C_EXECR, C_EXECI, C_ALUWB, C_BRANCH, C_JAL, C_JALR, C_JALR2, C_LUI, C_AUIPC, C_FAULT;

    task automatic add(input logic r, input logic [6:0] o, input logic rd, input ctrl_t e,
                       input string t);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = rd; v.exp = e; v.tag = t;
        vecs.push_back(v);
    endtask

    // Scoreboard consumer: compares the DUT outputs mid-cycle against the
    // expectation pushed when that cycle's inputs were driven.
    ctrl_t mon_exp, mon_act;
    string mon_tag;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write,
                       alu_src_a, alu_src_b, alu_op, result_src, fault};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", mon_tag, mon_act, mon_exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        op        = 7'd0;
        mem_ready = 1'b0;

        C_DEF    = mk(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        C_FETCH  = mk(7'b1000000, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0);
        C_FETCHR = mk(7'b1001100, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0);
        C_DECODE = mk(7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0);
        C_MEMADR = mk(7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0);
        C_MEMRD  = mk(7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        C_MEMWB  = mk(7'b0000001, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0);
        C_MEMWR  = mk(7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        C_EXECR  = mk(7'b0000000, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0);
        C_EXECI  = mk(7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0, 1'b0);
        C_ALUWB  = mk(7'b0000001, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        C_BRANCH = mk(7'b0000010, 2'd2, 2'd0, 2'd1, 2'd0, 1'b0);
        C_JAL    = mk(7'b0000100, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0);
        C_JALR   = mk(7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0);
        C_JALR2  = mk(7'b0000100, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0);
        C_LUI    = mk(7'b0000000, 2'd3, 2'd1, 2'd0, 2'd0, 1'b0);
        C_AUIPC  = mk(7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0);
        C_FAULT  = mk(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

        // Reset state.
        add(1, OP_R, 0, C_DEF, "reset0");
        add(1, OP_R, 0, C_DEF, "reset1");
        // R-type, zero-wait: 4 cycles; next FETCH row checks the return.
        add(0, OP_R, 1, C_FETCHR, "r_fetch");
        add(0, OP_R, 0, C_DECODE, "r_decode");
        add(0, OP_R, 1, C_EXECR,  "r_exec");
        add(0, OP_R, 1, C_ALUWB,  "r_wb");
        // I-type.
        add(0, OP_I, 1, C_FETCHR, "i_fetch");
        add(0, OP_I, 1, C_DECODE, "i_decode");
        add(0, OP_I, 0, C_EXECI,  "i_exec");
        add(0, OP_I, 1, C_ALUWB,  "i_wb");
        // Load with two wait cycles in MEMREAD: 7 cycles.
        add(0, OP_LOAD, 1, C_FETCHR, "ld_fetch");
        add(0, OP_LOAD, 1, C_DECODE, "ld_decode");
        add(0, OP_LOAD, 1, C_MEMADR, "ld_memadr");
        add(0, OP_LOAD, 0, C_MEMRD,  "ld_wait0");
        add(0, OP_LOAD, 0, C_MEMRD,  "ld_wait1");
        add(0, OP_LOAD, 1, C_MEMRD,  "ld_read");
        add(0, OP_LOAD, 1, C_MEMWB,  "ld_wb");
        // Store with one wait cycle.
        add(0, OP_STORE, 1, C_FETCHR, "st_fetch");
        add(0, OP_STORE, 1, C_DECODE, "st_decode");
        add(0, OP_STORE, 1, C_MEMADR, "st_memadr");
        add(0, OP_STORE, 0, C_MEMWR,  "st_wait");
        add(0, OP_STORE, 1, C_MEMWR,  "st_write");
        // Branch: 3 cycles.
        add(0, OP_BR, 1, C_FETCHR, "br_fetch");
        add(0, OP_BR, 1, C_DECODE, "br_decode");
        add(0, OP_BR, 1, C_BRANCH, "br_branch");
        // JAL: 4 cycles.
        add(0, OP_JAL, 1, C_FETCHR, "jal_fetch");
        add(0, OP_JAL, 1, C_DECODE, "jal_decode");
        add(0, OP_JAL, 1, C_JAL,    "jal_jal");
        add(0, OP_JAL, 1, C_ALUWB,  "jal_wb");
        // JALR: 5 cycles.
        add(0, OP_JALR, 1, C_FETCHR, "jalr_fetch");
        add(0, OP_JALR, 1, C_DECODE, "jalr_decode");
        add(0, OP_JALR, 1, C_JALR,   "jalr_jalr");
        add(0, OP_JALR, 1, C_JALR2,  "jalr_jalr2");
        add(0, OP_JALR, 1, C_ALUWB,  "jalr_wb");
        // LUI and AUIPC.
        add(0, OP_LUI, 1, C_FETCHR, "lui_fetch");
        add(0, OP_LUI, 1, C_DECODE, "lui_decode");
        add(0, OP_LUI, 1, C_LUI,    "lui_lui");
        add(0, OP_LUI, 1, C_ALUWB,  "lui_wb");
        add(0, OP_AUIPC, 1, C_FETCHR, "auipc_fetch");
        add(0, OP_AUIPC, 1, C_DECODE, "auipc_decode");
        add(0, OP_AUIPC, 1, C_AUIPC,  "auipc_auipc");
        add(0, OP_AUIPC, 1, C_ALUWB,  "auipc_wb");
        // Timeout boundary: ready arrives on the 16th FETCH cycle, success wins.
        for (int i = 0; i < 15; i++) add(0, OP_R, 0, C_FETCH, "fetch_edge_wait");
        add(0, OP_R, 1, C_FETCHR, "fetch_edge_done");
        add(0, OP_R, 1, C_DECODE, "fetch_edge_decode");
        add(0, OP_R, 1, C_EXECR,  "fetch_edge_exec");
        add(0, OP_R, 1, C_ALUWB,  "fetch_edge_wb");
        // Reset held 3 cycles in the middle of a stalled MEMREAD.
        add(0, OP_LOAD, 1, C_FETCHR, "rst_ld_fetch");
        add(0, OP_LOAD, 1, C_DECODE, "rst_ld_decode");
        add(0, OP_LOAD, 1, C_MEMADR, "rst_ld_memadr");
        add(0, OP_LOAD, 0, C_MEMRD,  "rst_ld_wait");
        for (int i = 0; i < 3; i++) add(1, OP_LOAD, 0, C_DEF, "rst_mid_read");
        add(0, OP_R, 0, C_FETCH,  "post_rst_fetch");
        add(0, OP_R, 1, C_FETCHR, "post_rst_fetch_rdy");
        add(0, OP_R, 1, C_DECODE, "post_rst_decode");
        add(0, OP_R, 1, C_EXECR,  "post_rst_exec");
        add(0, OP_R, 1, C_ALUWB,  "post_rst_wb");
        // FETCH timeout: 16 waits then sticky FAULT, ignoring mem_ready.
        for (int i = 0; i < 16; i++) add(0, OP_R, 0, C_FETCH, "fetch_to_wait");
        for (int i = 0; i < 3; i++)  add(0, OP_R, 1, C_FAULT, "fetch_to_fault");
        add(1, OP_R, 1, C_DEF, "fault_reset");
        // Illegal opcode.
        add(0, OP_BAD, 1, C_FETCHR, "bad_fetch");
        add(0, OP_BAD, 1, C_DECODE, "bad_decode");
        for (int i = 0; i < 3; i++) add(0, OP_BAD, 1, C_FAULT, "bad_fault");
        add(1, OP_BAD, 1, C_DEF, "bad_reset");
        // MEMWRITE timeout.
        add(0, OP_STORE, 1, C_FETCHR, "st_to_fetch");
        add(0, OP_STORE, 1, C_DECODE, "st_to_decode");
        add(0, OP_STORE, 1, C_MEMADR, "st_to_memadr");
        for (int i = 0; i < 16; i++) add(0, OP_STORE, 0, C_MEMWR, "st_to_wait");
        for (int i = 0; i < 2; i++)  add(0, OP_STORE, 1, C_FAULT, "st_to_fault");
        add(1, OP_STORE, 0, C_DEF, "st_to_reset");
        add(0, OP_BR, 0, C_FETCH, "final_fetch");

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            reset     = vecs[k].rst;
            op        = vecs[k].op;
            mem_ready = vecs[k].rdy;
            exp_q.push_back(vecs[k].exp);
            tag_q.push_back(vecs[k].tag);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
